// File: rtl/rec_tq_pkg.sv
// rec_tq_pkg: shared transform-size constants, row record and block-length helper for the rec_tq datapath
package rec_tq_pkg;

    localparam int DW    = 16;
    localparam int LANES = 32;
    localparam int RW    = DW * LANES;

    localparam logic [1:0] TS_4  = 2'd0;
    localparam logic [1:0] TS_8  = 2'd1;
    localparam logic [1:0] TS_16 = 2'd2;
    localparam logic [1:0] TS_32 = 2'd3;

    typedef struct packed {
        logic [RW-1:0] data;
        logic [1:0]    ts;
        logic          last;
    } row_t;

    function automatic logic [5:0] rows_per_blk(input logic [1:0] ts);
        return 6'd4 << ts;
    endfunction

endpackage

// File: rtl/pe_o_perm.sv
// pe_o_perm: combinational even/odd butterfly-order to natural-order lane restore, selected by transize
module pe_o_perm
    import rec_tq_pkg::*;
(
    input  logic [1:0]    ts_i,
    input  logic [RW-1:0] data_i,
    output logic [RW-1:0] data_o
);

    // Destination lane of butterfly lane k: the upper half of each group holds the odd
    // outputs, the lower half recurses on the even outputs with a doubled stride.
    function automatic int pidx(input int ts, input int k);
        int n, j, s, m, r;
        logic done;
        if (ts == 0) return k;
        n    = 4 << ts;
        j    = k % n;
        s    = 1;
        m    = n;
        r    = 0;
        done = 1'b0;
        for (int l = 0; l < 3; l++)
            if (!done && m >= 8) begin
                if (j >= m / 2) begin
                    r    = s * (2 * (j - m / 2) + 1);
                    done = 1'b1;
                end else begin
                    s = s * 2;
                    m = m / 2;
                end
            end
        if (!done) r = s * j;
        return k - j + r;
    endfunction

    logic [3:0][RW-1:0] cand;

    for (genvar t = 0; t < 4; t++) begin : g_t
        for (genvar k = 0; k < LANES; k++) begin : g_k
            assign cand[t][pidx(t, k)*DW +: DW] = data_i[k*DW +: DW];
        end
    end

    assign data_o = cand[ts_i];

endmodule

// File: rtl/pe_o.sv
// pe_o: output lane reorder with registered row, one-entry skid buffer and block row tagging
module pe_o
    import rec_tq_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    i_transize,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [RW-1:0] i_data,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [RW-1:0] o_data,
    output logic [1:0]    o_transize,
    output logic          o_last,
    output logic          o_err
);

    logic [RW-1:0] perm;
    row_t          main_q, main_d, skid_q, skid_d, new_row;
    logic          main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
    logic          err_q, err_d;
    logic [4:0]    row_cnt_q, row_cnt_d;
    logic [1:0]    blk_q, blk_d, blk_use;
    logic          acc, drain, is_last;

    pe_o_perm u_perm (
        .ts_i   (i_transize),
        .data_i (i_data),
        .data_o (perm)
    );

    assign acc     = i_valid & ~skid_vld_q;
    assign drain   = main_vld_q & i_ready;
    // Block length is latched on the first row; later rows count against it even if transize changes.
    assign blk_use = (row_cnt_q == 5'd0) ? i_transize : blk_q;
    assign is_last = {1'b0, row_cnt_q} == rows_per_blk(blk_use) - 6'd1;
    assign new_row = '{data: perm, ts: i_transize, last: is_last};

    always_comb begin
        main_d     = main_q;
        main_vld_d = main_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        row_cnt_d  = row_cnt_q;
        blk_d      = blk_q;
        err_d      = 1'b0;
        if (drain || !main_vld_q) begin
            if (skid_vld_q) begin
                main_d     = skid_q;
                main_vld_d = 1'b1;
                skid_vld_d = 1'b0;
            end else begin
                main_vld_d = acc;
                main_d     = acc ? new_row : main_q;
            end
        end else if (acc) begin
            skid_d     = new_row;
            skid_vld_d = 1'b1;
        end
        if (acc) begin
            row_cnt_d = is_last ? 5'd0 : row_cnt_q + 5'd1;
            blk_d     = blk_use;
            err_d     = (row_cnt_q != 5'd0) && (i_transize != blk_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            row_cnt_q  <= 5'd0;
            blk_q      <= TS_4;
            err_q      <= 1'b0;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            row_cnt_q  <= row_cnt_d;
            blk_q      <= blk_d;
            err_q      <= err_d;
        end
    end

    assign o_ready    = ~skid_vld_q;
    assign o_valid    = main_vld_q;
    assign o_data     = main_q.data;
    assign o_transize = main_q.ts;
    assign o_last     = main_q.last;
    assign o_err      = err_q;

endmodule

// File: tb/tb_pe_o.sv
// tb_pe_o: directed self-checking bench for the pe_o output reorder stage
module tb_pe_o;
    import rec_tq_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    i_transize;
    logic          i_valid;
    logic          o_ready;
    logic [RW-1:0] i_data;
    logic          o_valid;
    logic          i_ready;
    logic [RW-1:0] o_data;
    logic [1:0]    o_transize;
    logic          o_last;
    logic          o_err;

    int n_cmp = 0;
    int n_err = 0;

    int P32 [32] = '{0, 8, 16, 24, 4, 12, 20, 28, 2, 6, 10, 14, 18, 22, 26, 30,
                     1, 3, 5, 7, 9, 11, 13, 15, 17, 19, 21, 23, 25, 27, 29, 31};
    int P16 [16] = '{0, 4, 8, 12, 2, 6, 10, 14, 1, 3, 5, 7, 9, 11, 13, 15};
    int P8  [8]  = '{0, 2, 4, 6, 1, 3, 5, 7};

    pe_o dut (
        .clk        (clk),
        .rst        (rst),
        .i_transize (i_transize),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_data     (i_data),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_data     (o_data),
        .o_transize (o_transize),
        .o_last     (o_last),
        .o_err      (o_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int tp(input int ts, input int k);
        case (ts)
            3:       return P32[k];
            2:       return (k & 16) + P16[k & 15];
            1:       return (k & 24) + P8[k & 7];
            default: return k;
        endcase
    endfunction

    // Input-side permutation: butterfly lane k carries natural lane P[k].
    function automatic logic [RW-1:0] to_bf(input logic [RW-1:0] nat, input int ts);
        logic [RW-1:0] bf;
        for (int k = 0; k < LANES; k++) bf[k*DW +: DW] = nat[tp(ts, k)*DW +: DW];
        return bf;
    endfunction

    function automatic logic [RW-1:0] seq_row(input int tag);
        logic [RW-1:0] r;
        for (int n = 0; n < LANES; n++) r[n*DW +: DW] = 16'(tag * 256 + n);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        i_valid    = 1'b0;
        i_ready    = 1'b0;
        i_transize = TS_4;
        i_data     = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic drive(input int ts, input logic [RW-1:0] d);
        i_valid    = 1'b1;
        i_transize = 2'(ts);
        i_data     = d;
    endtask

    initial begin
        logic [RW-1:0] exp_v, nat;
        int sent, got;

        do_reset();
        chk("rst_valid", RW'(o_valid), RW'(0));
        chk("rst_ready", RW'(o_ready), RW'(1));
        chk("rst_data", o_data, '0);
        chk("rst_ts", RW'(o_transize), RW'(0));
        chk("rst_last", RW'(o_last), RW'(0));
        chk("rst_err", RW'(o_err), RW'(0));

        // 32x32 row with lane k = k
        i_ready = 1'b1;
        drive(3, seq_row(0));
        tick();
        i_valid = 1'b0;
        for (int k = 0; k < LANES; k++) exp_v[tp(3, k)*DW +: DW] = 16'(k);
        chk("t1_valid", RW'(o_valid), RW'(1));
        chk("t1_lane0", RW'(o_data[0*DW +: DW]), RW'(0));
        chk("t1_lane8", RW'(o_data[8*DW +: DW]), RW'(1));
        chk("t1_lane16", RW'(o_data[16*DW +: DW]), RW'(2));
        chk("t1_lane24", RW'(o_data[24*DW +: DW]), RW'(3));
        chk("t1_lane1", RW'(o_data[1*DW +: DW]), RW'(16));
        chk("t1_lane31", RW'(o_data[31*DW +: DW]), RW'(31));
        chk("t1_row", o_data, exp_v);
        chk("t1_ts", RW'(o_transize), RW'(3));

        // 8x8 block back-to-back
        do_reset();
        i_ready = 1'b1;
        for (int r = 0; r < 8; r++) begin
            drive(1, to_bf(seq_row(r), 1));
            tick();
            chk("t2_valid", RW'(o_valid), RW'(1));
            chk("t2_row", o_data, seq_row(r));
            chk("t2_last", RW'(o_last), RW'(r == 7));
        end
        i_valid = 1'b0;
        tick();
        chk("t2_idle", RW'(o_valid), RW'(0));

        // 16x16 stream with a 3-cycle downstream stall
        do_reset();
        sent = 0;
        got  = 0;
        for (int c = 0; c < 40 && got < 16; c++) begin
            i_ready    = !(c >= 4 && c <= 6);
            i_valid    = sent < 16;
            i_transize = TS_16;
            i_data     = to_bf(seq_row(sent), 2);
            if (c >= 5 && c <= 7) chk("t3_hold", o_data, seq_row(3));
            if (c == 5) chk("t3_rdy_low", RW'(o_ready), RW'(0));
            if (c == 7) chk("t3_absorb", RW'(sent), RW'(5));
            if (c == 8) chk("t3_rdy_back", RW'(o_ready), RW'(1));
            if (o_valid && i_ready) begin
                chk("t3_seq", o_data, seq_row(got));
                chk("t3_last", RW'(o_last), RW'(got == 15));
                got++;
            end
            if (i_valid && o_ready) sent++;
            tick();
        end
        i_valid = 1'b0;
        chk("t3_count", RW'(got), RW'(16));
        chk("t3_sent", RW'(sent), RW'(16));

        // composition with the input permutation on random data
        for (int ts = 0; ts < 4; ts++) begin
            do_reset();
            i_ready = 1'b1;
            for (int n = 0; n < LANES; n++) nat[n*DW +: DW] = 16'($urandom);
            drive(ts, to_bf(nat, ts));
            tick();
            i_valid = 1'b0;
            chk("t4_compose", o_data, nat);
            chk("t4_ts", RW'(o_transize), RW'(ts));
        end

        // transize change at row 2 of a 32x32 block
        do_reset();
        i_ready = 1'b1;
        for (int r = 0; r < 32; r++) begin
            drive(r == 2 ? 0 : 3, to_bf(seq_row(r), r == 2 ? 0 : 3));
            tick();
            chk("t5_row", o_data, seq_row(r));
            chk("t5_err", RW'(o_err), RW'(r == 2));
            chk("t5_last", RW'(o_last), RW'(r == 31));
            chk("t5_ts", RW'(o_transize), RW'(r == 2 ? 0 : 3));
        end
        i_valid = 1'b0;
        tick();
        chk("t5_err_end", RW'(o_err), RW'(0));

        // reset with main and skid both full
        do_reset();
        drive(3, to_bf(seq_row(0), 3));
        tick();
        drive(3, to_bf(seq_row(1), 3));
        tick();
        i_valid = 1'b0;
        chk("t6_full_rdy", RW'(o_ready), RW'(0));
        chk("t6_full_vld", RW'(o_valid), RW'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_vld", RW'(o_valid), RW'(0));
        chk("t6_rst_rdy", RW'(o_ready), RW'(1));
        chk("t6_rst_data", o_data, '0);
        i_ready = 1'b1;
        for (int r = 0; r < 8; r++) begin
            drive(1, to_bf(seq_row(r), 1));
            tick();
            chk("t6_row", o_data, seq_row(r));
            chk("t6_last", RW'(o_last), RW'(r == 7));
            chk("t6_err", RW'(o_err), RW'(0));
        end
        i_valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pe_o.md
Name: pe_o

Overview:
- Output-side lane reorder stage for the rec_tq transform datapath.
- Takes one 32-lane row per beat from the butterfly/transform core, where lanes arrive in even/odd butterfly order. Restores natural coefficient/sample order and registers the row.
- Provides a ready/valid skid buffer toward the transpose memory / quant stage and tags the last row of each block.
- Sits between the 1-D transform core and the transpose buffer, mirroring the input-side permutation stage.

Parameters:
- DW, 16, lane data width in bits
- LANES, 32, lanes per row (fixed; only 32 is supported)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_transize  in  2  0=4x4, 1=8x8, 2=16x16, 3=32x32; sampled on each accepted beat
- i_valid  in  1  input row valid
- o_ready  out  1  stage can accept a row this cycle
- i_data  in  DW*LANES  packed row, lane k at bits [k*DW +: DW], butterfly order
- o_valid  out  1  output row valid
- i_ready  in  1  downstream accepts this cycle
- o_data  out  DW*LANES  packed row, natural order
- o_transize  out  2  transize of the row on o_data
- o_last  out  1  row on o_data is the final row of its block
- o_err  out  1  one-cycle pulse: transize changed mid-block

Behaviour:
- Interface: one clock (clk), synchronous active-high reset (rst).
- Permutation rule: out lane P[k] = in lane k, where P depends on transize.
  - 3: P = 0,8,16,24,4,12,20,28, 2,6,10,...,30 (step 4 from 2), 1,3,5,...,31.
  - 2: two 16-lane groups at base 0 and 16, each P = b+0,4,8,12,2,6,10,14,1,3,5,...,15.
  - 1: four 8-lane groups at base 0/8/16/24, each P = b+0,2,4,6,1,3,5,7.
  - 0: identity.
- Pipeline: a main output register plus a one-entry skid register.
  - The permutation is applied before the main register.
  - Latency is 1 cycle from accept to o_valid.
  - Full throughput of 1 row/cycle when i_ready is held high.
- Handshakes:
  - Input accept = i_valid & o_ready.
  - Output transfer = o_valid & i_ready.
  - o_ready = ~skid_full; it is a registered signal.
- Skid rules:
  - On accept, if the main register is empty or drains this cycle, the row loads into main.
  - Otherwise it loads into skid, and o_ready drops the next cycle.
  - When main drains and skid is full, skid moves to main and skid empties.
  - o_data, o_transize and o_last are held stable while o_valid=1 and i_ready=0.
- Row counter:
  - 5-bit row_cnt and a latched blk_size, both updated on accept.
  - At row_cnt==0, blk_size <= i_transize.
  - Rows per block are 4<<blk_size.
  - The last row is row_cnt == (4<<blk_size)-1; it sets the o_last tag and wraps row_cnt to 0.
- Mid-block transize change:
  - If i_transize != blk_size on an accepted beat with row_cnt != 0, o_err pulses 1 cycle after accept.
  - The beat is still permuted with its own i_transize.
  - Counting continues with the latched blk_size.
- Reset values: o_valid=0, o_ready=1 (first cycle after rst deasserts), o_data=0, o_transize=0, o_last=0, o_err=0. row_cnt=0, blk_size=0, skid empty.
- Reset mid-block: pending rows in main and skid are discarded, and the counter restarts.
- Simultaneous events: accept and drain in the same cycle with skid empty keep main occupied with the new row and cause no bubble.

Decomposition:
- Shared package rec_tq_pkg holds:
  - TS_4/TS_8/TS_16/TS_32 transize constants
  - DW and LANES
  - a function returning rows-per-block from transize
- Natural sub-module: pe_o_perm, a purely combinational inverse permutation (transize, 32 lanes in/out).
- pe_o_perm must compose with the input permutation to identity; this is checked in the bench.

Test Plan:
- transize=3, lane k = k, i_ready=1 → one cycle later o_data lanes 0,8,16,24 hold 0,1,2,3, and lane 1 holds 16, lane 31 holds 31.
- transize=1, 8 rows back-to-back, i_ready=1 → o_valid high for 8 consecutive cycles, o_last only on row 7, each group restored to 0..7 order.
- transize=2 stream with i_ready low for 3 cycles starting mid-stream:
  - exactly one extra row is absorbed into skid;
  - o_ready falls the next cycle;
  - o_data is held stable throughout;
  - no row is lost or duplicated (check by sequence tag in lane 0).
- Compose with the input permutation for all 4 transize values on random data → output equals input.
- transize=0 at row 2 of a 32x32 block → o_err pulses once, o_last still occurs on row 31.
- Assert rst with both registers full → next cycle o_valid=0, o_ready=1, and a new block starts at row_cnt 0.
